// File: rtl/gps_round_sequencer.sv
// gps_round_sequencer
//   Sequences rounds of the gps code-generator over a range of SVs, captures
//   each round's ca/p/l codes into a small record FIFO and streams records out
//   as nine 32-bit words (w0 = sv/ca, w1..w4 = p_code MSW first,
//   w5..w8 = l_code MSW first).
// Ports:
//   gps_clk, async_rst_n_in    clock, async active-low reset
//   enable, continuous         run control (level)
//   sv_first, sv_count         sweep range, sampled at sweep start/reload
//   err_clr                    clears sticky timeout_err
//   start_round_out, sv_num_out   drive the gps block
//   ca_code_in, p_code_in, l_code_in, l_code_valid_in   gps results
//   rd_data, rd_valid, rd_ready   word stream, valid/ready handshake
//   busy, timeout_err, rounds_done  status
module gps_round_sequencer #(
   parameter int FIFO_DEPTH     = 2,
   parameter int TIMEOUT_CYCLES = 1024,
   parameter int GAP_CYCLES     = 2
) (
   input  logic         gps_clk,
   input  logic         async_rst_n_in,
   input  logic         enable,
   input  logic         continuous,
   input  logic [5:0]   sv_first,
   input  logic [5:0]   sv_count,
   input  logic         err_clr,
   output logic         start_round_out,
   output logic [5:0]   sv_num_out,
   input  logic [12:0]  ca_code_in,
   input  logic [127:0] p_code_in,
   input  logic [127:0] l_code_in,
   input  logic         l_code_valid_in,
   output logic [31:0]  rd_data,
   output logic         rd_valid,
   input  logic         rd_ready,
   output logic         busy,
   output logic         timeout_err,
   output logic [15:0]  rounds_done
);

   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam int GW = $clog2(GAP_CYCLES + 1);
   localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = $clog2(FIFO_DEPTH + 1);

   typedef enum logic [2:0] {
      S_IDLE, S_GAP, S_START, S_WAIT, S_CAPTURE, S_NEXT
   } state_t;

   typedef struct packed {
      logic [5:0]   sv;
      logic [12:0]  ca;
      logic [127:0] p;
      logic [127:0] l;
   } rec_t;

   state_t          state, state_nxt;
   logic [GW-1:0]   gap_cnt;
   logic [TW-1:0]   tmo_cnt;
   logic [5:0]      remaining;
   rec_t            cap_rec;
   rec_t            mem [FIFO_DEPTH];
   rec_t            head;
   logic [AW-1:0]   wr_ptr, rd_ptr;
   logic [CW-1:0]   occ;
   logic [3:0]      word_idx;

   logic fifo_full, fifo_empty, hs, pop;
   logic push, capture, tmo_hit, load_sweep, reload;
   logic [5:0] eff_count;

   function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
      return (p == AW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign eff_count  = (sv_count == 6'd0) ? 6'd1 : sv_count;
   assign fifo_full  = (occ == CW'(FIFO_DEPTH));
   assign fifo_empty = (occ == '0);
   assign rd_valid   = !fifo_empty;
   assign hs         = rd_valid && rd_ready;
   assign pop        = hs && (word_idx == 4'd8);
   assign busy       = (state != S_IDLE);
   // Decoded from state so the pulse is exactly one cycle wide.
   assign start_round_out = (state == S_START);

   // Next-state and control strobes
   always_comb begin
      state_nxt  = state;
      push       = 1'b0;
      capture    = 1'b0;
      tmo_hit    = 1'b0;
      load_sweep = 1'b0;
      reload     = 1'b0;
      case (state)
         S_IDLE: if (enable) begin
            load_sweep = 1'b1;
            state_nxt  = S_GAP;
         end
         S_GAP: if (gap_cnt == GW'(GAP_CYCLES - 1)) state_nxt = S_START;
         S_START: state_nxt = S_WAIT;
         S_WAIT: begin
            if (l_code_valid_in) begin
               capture   = 1'b1;
               state_nxt = S_CAPTURE;
            end else if (tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
               tmo_hit   = 1'b1;
               state_nxt = S_NEXT;
            end
         end
         // A pop of the last word frees the slot in the same cycle.
         S_CAPTURE: if (!fifo_full || pop) begin
            push      = 1'b1;
            state_nxt = S_NEXT;
         end
         S_NEXT: begin
            if (remaining == 6'd1) begin
               if (continuous && enable) begin
                  reload    = 1'b1;
                  state_nxt = S_GAP;
               end else begin
                  state_nxt = S_IDLE;
               end
            end else begin
               state_nxt = enable ? S_GAP : S_IDLE;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge gps_clk or negedge async_rst_n_in) begin
      if (!async_rst_n_in) begin
         state       <= S_IDLE;
         gap_cnt     <= '0;
         tmo_cnt     <= '0;
         sv_num_out  <= '0;
         remaining   <= '0;
         cap_rec     <= '0;
         timeout_err <= 1'b0;
         rounds_done <= '0;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         occ         <= '0;
         word_idx    <= '0;
      end else begin
         state   <= state_nxt;
         gap_cnt <= (state == S_GAP) ? gap_cnt + 1'b1 : '0;
         // Zero in START (and everywhere else), counts only while waiting.
         tmo_cnt <= (state == S_WAIT) ? tmo_cnt + 1'b1 : '0;

         if (load_sweep || reload) begin
            sv_num_out <= sv_first;
            remaining  <= eff_count;
         end else if (state == S_NEXT) begin
            sv_num_out <= sv_num_out + 1'b1;
            remaining  <= remaining - 1'b1;
         end

         if (capture) cap_rec <= '{sv: sv_num_out, ca: ca_code_in,
                                   p: p_code_in, l: l_code_in};

         if (tmo_hit)      timeout_err <= 1'b1;
         else if (err_clr) timeout_err <= 1'b0;

         if (push) begin
            rounds_done <= rounds_done + 1'b1;
            wr_ptr      <= ptr_inc(wr_ptr);
         end
         if (pop) rd_ptr <= ptr_inc(rd_ptr);
         case ({push, pop})
            2'b10:   occ <= occ + 1'b1;
            2'b01:   occ <= occ - 1'b1;
            default: occ <= occ;
         endcase

         if (hs) word_idx <= (word_idx == 4'd8) ? 4'd0 : word_idx + 1'b1;
      end
   end

   // Record storage needs no reset; occupancy gates everything read from it.
   always_ff @(posedge gps_clk) begin
      if (push) mem[wr_ptr] <= cap_rec;
   end

   assign head = mem[rd_ptr];

   always_comb begin
      rd_data = '0;
      if (!fifo_empty) begin
         case (word_idx)
            4'd0: rd_data = {7'b0, head.sv, 6'b0, head.ca};
            4'd1: rd_data = head.p[127:96];
            4'd2: rd_data = head.p[95:64];
            4'd3: rd_data = head.p[63:32];
            4'd4: rd_data = head.p[31:0];
            4'd5: rd_data = head.l[127:96];
            4'd6: rd_data = head.l[95:64];
            4'd7: rd_data = head.l[63:32];
            4'd8: rd_data = head.l[31:0];
            default: rd_data = '0;
         endcase
      end
   end

endmodule

// File: tb/tb_gps_round_sequencer.sv
module tb_gps_round_sequencer;

   localparam int GAP = 2;

   logic         gps_clk = 1'b0;
   logic         async_rst_n_in = 1'b0;
   logic         enable = 1'b0, continuous = 1'b0, err_clr = 1'b0;
   logic [5:0]   sv_first = '0, sv_count = '0;
   logic         start_round_out;
   logic [5:0]   sv_num_out;
   logic [12:0]  ca_code_in = '0;
   logic [127:0] p_code_in = '0, l_code_in = '0;
   logic         l_code_valid_in = 1'b0;
   logic [31:0]  rd_data;
   logic         rd_valid;
   logic         rd_ready = 1'b1;
   logic         busy, timeout_err;
   logic [15:0]  rounds_done;

   gps_round_sequencer #(.FIFO_DEPTH(2), .TIMEOUT_CYCLES(1024), .GAP_CYCLES(GAP)) dut (
      .gps_clk(gps_clk), .async_rst_n_in(async_rst_n_in),
      .enable(enable), .continuous(continuous),
      .sv_first(sv_first), .sv_count(sv_count), .err_clr(err_clr),
      .start_round_out(start_round_out), .sv_num_out(sv_num_out),
      .ca_code_in(ca_code_in), .p_code_in(p_code_in), .l_code_in(l_code_in),
      .l_code_valid_in(l_code_valid_in),
      .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
      .busy(busy), .timeout_err(timeout_err), .rounds_done(rounds_done)
   );

   always #5 gps_clk = ~gps_clk;

   int          n_vec = 0, n_err = 0;
   logic [31:0] exp_words [$];
   logic [5:0]  exp_sv [$];
   int          exp_rounds = 0;
   int          mock_delay = 300;   // 0 = gps never answers

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h want %h", tag, act, exp);
      end
   endtask

   // Mock gps: checks each start pulse, answers mock_delay cycles later.
   initial begin
      int   cd, low;
      logic prev;
      logic [5:0] m_sv;
      cd = 0; low = 100; prev = 1'b0; m_sv = '0;
      forever begin
         @(posedge gps_clk); #1;
         l_code_valid_in = 1'b0;
         if (!async_rst_n_in) begin
            cd = 0; prev = 1'b0; low = 100;
            continue;
         end
         if (cd > 0) begin
            cd--;
            if (cd == 0) begin
               ca_code_in = 13'($urandom);
               p_code_in  = {$urandom, $urandom, $urandom, $urandom};
               l_code_in  = {$urandom, $urandom, $urandom, $urandom};
               l_code_valid_in = 1'b1;
               exp_rounds++;
               exp_words.push_back({7'b0, m_sv, 6'b0, ca_code_in});
               for (int i = 3; i >= 0; i--) exp_words.push_back(p_code_in[i*32 +: 32]);
               for (int i = 3; i >= 0; i--) exp_words.push_back(l_code_in[i*32 +: 32]);
            end
         end
         if (start_round_out) begin
            chk("start_width", 32'(prev), 0);
            chk("gap_low", 32'(low >= GAP), 1);
            if (exp_sv.size() == 0) chk("unexpected_start", 1, 0);
            else chk("sv_num", 32'(sv_num_out), 32'(exp_sv.pop_front()));
            m_sv = sv_num_out;
            cd   = mock_delay;
            low  = 0;
         end else begin
            low++;
         end
         prev = start_round_out;
      end
   end

   // Consumer: compare every handshaken word against the scoreboard.
   initial begin
      forever begin
         @(negedge gps_clk);
         if (rd_valid && rd_ready) begin
            if (exp_words.size() == 0) chk("extra_word", 32'(rd_data), 32'hDEAD_BEEF);
            else chk("word", rd_data, exp_words.pop_front());
         end
      end
   end

   task automatic tick();
      @(posedge gps_clk); #2;
   endtask

   task automatic wait_sv_drained(input int budget);
      for (int i = 0; i < budget; i++) begin
         if (exp_sv.size() == 0) return;
         tick();
      end
      chk("wait_starts_timeout", 0, 1);
   endtask

   task automatic wait_idle(input int budget);
      repeat (3) tick();
      for (int i = 0; i < budget; i++) begin
         if (!busy && !rd_valid && exp_words.size() == 0) begin
            chk("rounds_done", 32'(rounds_done), 32'(exp_rounds));
            return;
         end
         tick();
      end
      chk("wait_idle_timeout", 0, 1);
   endtask

   task automatic run_sweep(input logic [5:0] first, input logic [5:0] cnt);
      sv_first = first; sv_count = cnt;
      for (int i = 0; i < ((cnt == 0) ? 1 : int'(cnt)); i++) exp_sv.push_back(6'(first + i));
      enable = 1'b1;
      wait_sv_drained(5000);
      enable = 1'b0;
      wait_idle(3000);
   endtask

   initial begin
      #23;
      chk("rst_rd_valid", 32'(rd_valid), 0);
      chk("rst_rd_data", rd_data, 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_start", 32'(start_round_out), 0);
      chk("rst_sv", 32'(sv_num_out), 0);
      chk("rst_err", 32'(timeout_err), 0);
      chk("rst_rounds", 32'(rounds_done), 0);
      async_rst_n_in = 1'b1;
      tick();

      // Single SV, then sv_count=0 treated as one
      run_sweep(6'd5, 6'd1);
      run_sweep(6'd9, 6'd0);

      // Sweep wrapping 63 -> 0
      run_sweep(6'd62, 6'd4);

      // Backpressure: stall on third capture, then drain in order
      rd_ready = 1'b0;
      sv_first = 6'd10; sv_count = 6'd4;
      for (int i = 0; i < 4; i++) exp_sv.push_back(6'(10 + i));
      enable = 1'b1;
      for (int i = 0; i < 3000 && exp_sv.size() > 1; i++) tick();
      repeat (400) tick();
      chk("bp_starts_left", 32'(exp_sv.size()), 1);
      chk("bp_busy", 32'(busy), 1);
      chk("bp_rounds", 32'(rounds_done), 32'(exp_rounds - 1));
      rd_ready = 1'b1;
      wait_sv_drained(3000);
      enable = 1'b0;
      wait_idle(3000);

      // Timeout on first SV, second SV answers
      mock_delay = 0;
      sv_first = 6'd20; sv_count = 6'd2;
      exp_sv.push_back(6'd20); exp_sv.push_back(6'd21);
      enable = 1'b1;
      for (int i = 0; i < 100 && exp_sv.size() > 1; i++) tick();
      mock_delay = 300;
      repeat (1020) tick();
      chk("tmo_err_early", 32'(timeout_err), 0);
      repeat (8) tick();
      chk("tmo_err_set", 32'(timeout_err), 1);
      wait_sv_drained(100);
      enable = 1'b0;
      wait_idle(3000);
      chk("tmo_err_sticky", 32'(timeout_err), 1);
      err_clr = 1'b1; tick(); err_clr = 1'b0; tick();
      chk("tmo_err_clr", 32'(timeout_err), 0);

      // Continuous, drop enable during round 3
      continuous = 1'b1;
      sv_first = 6'd40; sv_count = 6'd2;
      exp_sv.push_back(6'd40); exp_sv.push_back(6'd41); exp_sv.push_back(6'd40);
      enable = 1'b1;
      wait_sv_drained(5000);
      repeat (20) tick();
      enable = 1'b0;
      wait_idle(3000);
      continuous = 1'b0;

      // Async reset mid-WAIT with one record buffered
      rd_ready = 1'b0;
      sv_first = 6'd3; sv_count = 6'd2;
      exp_sv.push_back(6'd3); exp_sv.push_back(6'd4);
      enable = 1'b1;
      wait_sv_drained(3000);
      repeat (50) tick();
      chk("pre_rst_valid", 32'(rd_valid), 1);
      chk("pre_rst_rounds", 32'(rounds_done), 32'(exp_rounds));
      #1;
      async_rst_n_in = 1'b0;
      enable = 1'b0;
      #1;
      chk("arst_rd_valid", 32'(rd_valid), 0);
      chk("arst_start", 32'(start_round_out), 0);
      chk("arst_busy", 32'(busy), 0);
      chk("arst_rounds", 32'(rounds_done), 0);
      chk("arst_sv", 32'(sv_num_out), 0);
      exp_words.delete(); exp_sv.delete(); exp_rounds = 0;
      tick();
      async_rst_n_in = 1'b1;
      rd_ready = 1'b1;
      repeat (5) tick();
      chk("post_rst_busy", 32'(busy), 0);
      chk("post_rst_valid", 32'(rd_valid), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
